// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic inter-stage pipeline register with kill mask, flush and optional skid entry
// Main entry drives the outputs; the skid entry only absorbs a beat that arrives while main is stalled.
module pipe_stage_reg #(
  parameter int                DATA_W    = 64,
  parameter int                CTRL_W    = 9,
  parameter logic [CTRL_W-1:0] KILL_MASK = 9'h1FF,
  parameter int                SKID      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              kill_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              killed_out,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stateT;

  stateT             state;
  stateT             nextState;
  logic [DATA_W-1:0] mainData;
  logic [DATA_W-1:0] skidData;
  logic [CTRL_W-1:0] mainCtrl;
  logic [CTRL_W-1:0] skidCtrl;
  logic [CTRL_W-1:0] ctrlMasked;
  logic              mainKilled;
  logic              skidKilled;
  logic              accept;
  logic              pop;
  logic              loadMainIn;
  logic              loadMainSkid;
  logic              loadSkid;

  assign ctrlMasked = kill_in ? (ctrl_in & ~KILL_MASK) : ctrl_in;
  assign out_valid  = (state != EMPTY);
  assign pop        = out_valid & out_ready;
  assign accept     = in_valid & in_ready;

  // Without a skid entry the stage can only take a beat if main drains this same cycle.
  assign in_ready = ((SKID != 0) ? (state != TWO) : (!out_valid | out_ready)) & !flush & !rst;

  always_comb begin
    nextState    = state;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          nextState  = ONE;
          loadMainIn = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          loadMainIn = 1'b1;
        end else if (accept) begin
          nextState = TWO;
          loadSkid  = 1'b1;
        end else if (pop) begin
          nextState = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          nextState    = ONE;
          loadMainSkid = 1'b1;
        end
      end
      default: nextState = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= EMPTY;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mainData   <= '0;
      mainCtrl   <= '0;
      mainKilled <= 1'b0;
      skidData   <= '0;
      skidCtrl   <= '0;
      skidKilled <= 1'b0;
    end else if (flush) begin
      // Payload is left in place; only the control side is scrubbed.
      mainCtrl   <= '0;
      mainKilled <= 1'b0;
      skidCtrl   <= '0;
      skidKilled <= 1'b0;
    end else begin
      if (loadMainIn) begin
        mainData   <= data_in;
        mainCtrl   <= ctrlMasked;
        mainKilled <= kill_in;
      end else if (loadMainSkid) begin
        mainData   <= skidData;
        mainCtrl   <= skidCtrl;
        mainKilled <= skidKilled;
      end
      if (loadSkid) begin
        skidData   <= data_in;
        skidCtrl   <= ctrlMasked;
        skidKilled <= kill_in;
      end else if (loadMainSkid) begin
        skidData   <= '0;
        skidCtrl   <= '0;
        skidKilled <= 1'b0;
      end
    end
  end

  assign data_out   = mainData;
  assign ctrl_out   = mainCtrl;
  assign killed_out = mainKilled;
  assign count      = state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg, instance 0 is SKID=0, instance 1 is SKID=1
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inValid[2];
  logic        inReady[2];
  logic        killIn[2];
  logic        flush[2];
  logic        outValid[2];
  logic        outReady[2];
  logic        killedOut[2];
  logic [63:0] dataIn[2];
  logic [63:0] dataOut[2];
  logic [8:0]  ctrlIn[2];
  logic [8:0]  ctrlOut[2];
  logic [1:0]  count[2];
  logic        monEn = 1'b0;
  int          testsRun = 0;
  int          testsFailed = 0;

  for (genvar g = 0; g < 2; g++) begin : gDut
    pipe_stage_reg #(
      .DATA_W   (64),
      .CTRL_W   (9),
      .KILL_MASK((g == 1) ? 9'h0F0 : 9'h1FF),
      .SKID     (g)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid[g]),
      .in_ready  (inReady[g]),
      .data_in   (dataIn[g]),
      .ctrl_in   (ctrlIn[g]),
      .kill_in   (killIn[g]),
      .flush     (flush[g]),
      .out_valid (outValid[g]),
      .out_ready (outReady[g]),
      .data_out  (dataOut[g]),
      .ctrl_out  (ctrlOut[g]),
      .killed_out(killedOut[g]),
      .count     (count[g])
    );
  end

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: queue depth is the occupancy, front is the beat on the outputs.
  for (genvar g = 0; g < 2; g++) begin : gMon
    localparam logic [8:0] MASK = (g == 1) ? 9'h0F0 : 9'h1FF;
    logic [73:0] sbq[$];
    always @(negedge clk) begin
      if (monEn) begin
        automatic int          sz = sbq.size();
        automatic logic        expRdy;
        automatic logic [73:0] front;
        expRdy = !rst && !flush[g] && ((g == 1) ? (sz < 2) : (sz == 0 || outReady[g]));
        checkVal($sformatf("d%0d.in_ready", g), inReady[g], expRdy);
        checkVal($sformatf("d%0d.count", g), count[g], sz);
        checkVal($sformatf("d%0d.out_valid", g), outValid[g], sz > 0);
        if (rst || flush[g]) begin
          sbq.delete();
        end else begin
          if (sz > 0 && outReady[g]) begin
            front = sbq.pop_front();
            checkVal($sformatf("d%0d.data", g), dataOut[g], front[63:0]);
            checkVal($sformatf("d%0d.ctrl", g), ctrlOut[g], front[72:64]);
            checkVal($sformatf("d%0d.killed", g), killedOut[g], front[73]);
          end
          if (inValid[g] && expRdy) begin
            sbq.push_back({killIn[g], killIn[g] ? (ctrlIn[g] & ~MASK) : ctrlIn[g], dataIn[g]});
          end
        end
      end
    end
  end

  task automatic setIn(input int d, input logic v, input logic [63:0] data, input logic [8:0] ctrl,
                       input logic k);
    inValid[d] = v;
    dataIn[d]  = data;
    ctrlIn[d]  = ctrl;
    killIn[d]  = k;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      setIn(d, 1'b0, 64'h0, 9'h0, 1'b0);
      flush[d]    = 1'b0;
      outReady[d] = 1'b0;
    end
    step(1);
    monEn = 1'b1;
    step(1);
    for (int d = 0; d < 2; d++) begin
      checkVal($sformatf("rst%0d.count", d), count[d], 2'd0);
      checkVal($sformatf("rst%0d.out_valid", d), outValid[d], 1'b0);
      checkVal($sformatf("rst%0d.data", d), dataOut[d], 64'h0);
      checkVal($sformatf("rst%0d.ctrl", d), ctrlOut[d], 9'h0);
      checkVal($sformatf("rst%0d.killed", d), killedOut[d], 1'b0);
    end
    rst = 1'b0;

    // Two beats into a stalled skid stage, then drain in order.
    setIn(1, 1'b1, 64'hA, 9'h001, 1'b0);
    step(1);
    setIn(1, 1'b1, 64'hB, 9'h002, 1'b0);
    step(1);
    setIn(1, 1'b0, 64'h0, 9'h0, 1'b0);
    checkVal("t2.count", count[1], 2'd2);
    checkVal("t2.in_ready", inReady[1], 1'b0);
    checkVal("t2.data", dataOut[1], 64'hA);
    outReady[1] = 1'b1;
    step(1);
    checkVal("t2.pop1.data", dataOut[1], 64'hB);
    checkVal("t2.pop1.count", count[1], 2'd1);
    step(1);
    checkVal("t2.pop2.count", count[1], 2'd0);
    outReady[1] = 1'b0;

    // Killed beat: mask 0F0 clears the middle nibble only.
    setIn(1, 1'b1, 64'h1234, 9'h1FF, 1'b1);
    step(1);
    setIn(1, 1'b1, 64'h99, 9'h003, 1'b0);
    checkVal("t3.ctrl", ctrlOut[1], 9'h10F);
    checkVal("t3.killed", killedOut[1], 1'b1);
    checkVal("t3.data", dataOut[1], 64'h1234);
    step(1);
    setIn(1, 1'b0, 64'h0, 9'h0, 1'b0);
    checkVal("t1.count_before", count[1], 2'd2);

    // Reset mid-stream with a full stage and upstream still offering.
    rst = 1'b1;
    setIn(1, 1'b1, 64'hDEAD, 9'h1FF, 1'b0);
    #1;
    checkVal("t1.in_ready_rst", inReady[1], 1'b0);
    step(1);
    checkVal("t1.in_ready_rst2", inReady[1], 1'b0);
    step(1);
    rst = 1'b0;
    setIn(1, 1'b0, 64'h0, 9'h0, 1'b0);
    checkVal("t1.count", count[1], 2'd0);
    checkVal("t1.out_valid", outValid[1], 1'b0);
    checkVal("t1.ctrl", ctrlOut[1], 9'h0);

    // Flush a full stage while a new beat is offered.
    setIn(1, 1'b1, 64'h55, 9'h011, 1'b0);
    step(1);
    setIn(1, 1'b1, 64'h66, 9'h022, 1'b1);
    step(1);
    setIn(1, 1'b1, 64'h77, 9'h0FF, 1'b0);
    flush[1] = 1'b1;
    #1;
    checkVal("t4.in_ready", inReady[1], 1'b0);
    step(1);
    flush[1] = 1'b0;
    setIn(1, 1'b0, 64'h0, 9'h0, 1'b0);
    checkVal("t4.count", count[1], 2'd0);
    checkVal("t4.out_valid", outValid[1], 1'b0);
    checkVal("t4.ctrl", ctrlOut[1], 9'h0);
    checkVal("t4.killed", killedOut[1], 1'b0);
    checkVal("t4.data_held", dataOut[1], 64'h55);

    // Full-throughput streaming through the single-entry stage.
    outReady[0] = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      setIn(0, 1'b1, 64'(i), 9'(i), 1'b0);
      step(1);
      checkVal($sformatf("t5.valid%0d", i), outValid[0], 1'b1);
      checkVal($sformatf("t5.data%0d", i), dataOut[0], 64'(i));
    end
    setIn(0, 1'b0, 64'h0, 9'h0, 1'b0);
    step(1);

    // Random traffic on both instances.
    for (int c = 0; c < 10000; c++) begin
      for (int d = 0; d < 2; d++) begin
        setIn(d, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 9'($urandom),
              ($urandom_range(0, 7) == 0));
        outReady[d] = ($urandom_range(0, 3) != 0);
        flush[d]    = ($urandom_range(0, 63) == 0);
      end
      step(1);
    end
    for (int d = 0; d < 2; d++) begin
      setIn(d, 1'b0, 64'h0, 9'h0, 1'b0);
      flush[d]    = 1'b0;
      outReady[d] = 1'b1;
    end
    step(4);
    for (int d = 0; d < 2; d++) begin
      checkVal($sformatf("t6.drain%0d", d), count[d], 2'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
